// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM pipeline stage (master) and dmem_lsu (slave).
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed data RAM with RV32I load/store sizing, fault checks and a
// fixed wait-state valid/ready handshake.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept, capture, commit;

  logic              ex_we;
  logic [2:0]        ex_f3;
  logic [ADDR_W-1:0] ex_addr;
  logic [31:0]       ex_wdata;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic              illegal, misal, oor, fault;
  logic [3:0]        be;
  logic [31:0]       wlane, rword;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  logic [31:0]       mem [DEPTH_WORDS];

  assign bus.req_ready = (state_q != WAIT);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero wait states commit at the accept edge, so execute straight from the bus.
  always_comb begin
    if (state_q == WAIT) begin
      ex_we    = we_q;
      ex_f3    = f3_q;
      ex_addr  = addr_q;
      ex_wdata = wdata_q;
    end else begin
      ex_we    = bus.req_we;
      ex_f3    = bus.req_funct3;
      ex_addr  = bus.req_addr;
      ex_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    off     = ex_addr[1:0];
    idx     = ex_addr[IDX_W+1:2];
    illegal = 1'b0;
    misal   = 1'b0;
    case (ex_f3)
      3'b000:         ;
      3'b001:         misal = off[0];
      3'b010:         misal = |off;
      3'b100, 3'b101: begin
        illegal = ex_we;
        misal   = ex_f3[0] & off[0];
      end
      default:        illegal = 1'b1;
    endcase
    oor   = (ex_addr >> 2) >= ADDR_W'(DEPTH_WORDS);
    fault = illegal | misal | oor;

    case (ex_f3[1:0])
      2'b00:   begin be = 4'b0001 << off;                       wlane = {4{ex_wdata[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011;           wlane = {2{ex_wdata[15:0]}}; end
      default: begin be = 4'b1111;                              wlane = ex_wdata;            end
    endcase

    rword = mem[idx];
    rbyte = rword[{off, 3'b000} +: 8];
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    rdata_d = '0;
    if (!fault && !ex_we) begin
      case (ex_f3)
        3'b000:  rdata_d = {{24{rbyte[7]}}, rbyte};
        3'b001:  rdata_d = {{16{rhalf[15]}}, rhalf};
        3'b010:  rdata_d = rword;
        3'b100:  rdata_d = {24'd0, rbyte};
        3'b101:  rdata_d = {16'd0, rhalf};
        default: rdata_d = '0;
      endcase
    end
    err_d = fault;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // RAM is not reset; a write landing on an edge while rst_n is low is dropped.
  always_ff @(posedge clk) begin
    if (commit && rst_n && ex_we && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end
endmodule
